// File: rtl/actmem_gather_pkg.sv
// actmem_gather_pkg: shared FSM encoding and derived-size helper for the junction datapath
package actmem_gather_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int cycles_per_junction(input int fo, input int p, input int z);
    return fo * p / z;
  endfunction
endpackage

// File: rtl/actmem_gather_bank.sv
// actmem_bank: single-port activation bank, synchronous read-first read with enable
module actmem_bank #(
  parameter int depth = 4,
  parameter int bw = 8,
  localparam int RW = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [RW-1:0] raddr,
  output logic [bw-1:0] rdata,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [bw-1:0] wdata
);
  logic [bw-1:0] mem [depth];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // storage is never reset; only the read register is, so a colliding write is seen next access
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/actmem_gather.sv
// actmem_gather: sequences a junction's cycles, gathers z interleaved activations per beat
module actmem_gather
  import actmem_gather_pkg::*;
#(
  parameter int fo = 2,
  parameter int p = 32,
  parameter int z = 8,
  parameter int bw = 8,
  localparam int C = cycles_per_junction(fo, p, z),
  localparam int CW = $clog2(C),
  localparam int AW = $clog2(p),
  localparam int RW = $clog2(p / z),
  localparam int ZW = $clog2(z)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   cycle_index,
  input  logic [AW*z-1:0] memory_index_package,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [bw-1:0]   wr_data,
  output logic            act_valid,
  input  logic            act_ready,
  output logic [bw*z-1:0] act_package,
  output logic [CW-1:0]   act_cycle,
  output logic            addr_err
);
  state_t state, state_n;
  logic issue, last, fin;
  logic [z-1:0] bad;
  assign busy = state != IDLE;
  assign issue = state == RUN && (!act_valid || act_ready);
  assign last = cycle_index == CW'(C - 1);
  assign fin = state == DRAIN && act_valid && act_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (issue && last ? DRAIN : RUN) :
                              (fin ? IDLE : DRAIN);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cycle_index <= '0;
      act_cycle <= '0;
      act_valid <= 1'b0;
      addr_err <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      act_valid <= issue || (act_valid && !act_ready);
      if (issue) act_cycle <= cycle_index;
      if (state == IDLE && start) begin
        cycle_index <= '0;
        addr_err <= 1'b0;
      end else if (issue) begin
        cycle_index <= last ? cycle_index : cycle_index + CW'(1);
        addr_err <= addr_err | (|bad);
      end
    end
  // a lane whose bank bits disagree with its lane number is flagged but still read by row
  for (genvar j = 0; j < z; j++) begin : g_lane
    assign bad[j] = memory_index_package[AW*j +: ZW] != ZW'(j);
    actmem_bank #(.depth(p / z), .bw(bw)) u_bank (
      .clk(clk),
      .reset(reset),
      .re(issue),
      .raddr(memory_index_package[AW*j+ZW +: RW]),
      .rdata(act_package[bw*j +: bw]),
      .we(wr_en && wr_addr[ZW-1:0] == ZW'(j)),
      .waddr(wr_addr[AW-1:ZW]),
      .wdata(wr_data)
    );
  end
endmodule

// File: tb/tb_actmem_gather.sv
// tb_actmem_gather: table, scripted and randomized checks against a behavioural activation model
module tb_actmem_gather;
  logic clk = 0, reset = 1, start = 0, wr_en = 0, act_ready = 0, bad5 = 0, mon_en = 0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic busy, done, act_valid, addr_err;
  logic [2:0] cycle_index, act_cycle;
  logic [39:0] mip;
  logic [63:0] act_package;
  logic [7:0] act [32];
  logic [1:0] rowtab [8][8];
  int checks = 0, errors = 0, beats = 0;
  typedef struct {
    logic start, ready, busy, valid, done;
    logic [2:0] cidx, acyc;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  actmem_gather #(.fo(2), .p(32), .z(8), .bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .cycle_index(cycle_index), .memory_index_package(mip),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_package(act_package),
    .act_cycle(act_cycle), .addr_err(addr_err)
  );

  // stand-in interleaver: lane j always targets bank j, row from a per-run table
  always_comb begin
    mip = '0;
    for (int j = 0; j < 8; j++) mip[j*5 +: 5] = {rowtab[cycle_index][j], 3'(j)};
    if (bad5) mip[25 +: 5] = 5'h0C;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_pkg(input logic [2:0] c);
    logic [63:0] e;
    e = '0;
    for (int j = 0; j < 8; j++) begin
      int a;
      a = (bad5 && j == 5) ? 13 : int'(rowtab[c][j]) * 8 + j;
      e[j*8 +: 8] = act[a];
    end
    return e;
  endfunction

  // every valid beat must be the next expected cycle with the model's data
  always @(negedge clk)
    if (mon_en && act_valid) begin
      chk("act_cycle", 64'(act_cycle), 64'(beats));
      chk("cycle_index", 64'(cycle_index), 64'(beats + 1 > 7 ? 7 : beats + 1));
      chk("act_package", act_package, exp_pkg(3'(beats)));
      if (act_ready) beats++;
    end

  task automatic new_rows();
    for (int c = 0; c < 8; c++)
      for (int j = 0; j < 8; j++) rowtab[c][j] = 2'($urandom_range(0, 3));
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(posedge clk); #1 wr_en = 1; wr_addr = 5'(a); wr_data = d;
    @(posedge clk); #1 wr_en = 0; act[a] = d;
  endtask

  task automatic run(input int mode, input string tag);
    int ndone, stall;
    ndone = 0; stall = 0; beats = 0; mon_en = 1;
    @(posedge clk); #1 start = 1; act_ready = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 80; i++) begin
      if (mode == 1) begin
        act_ready = !(beats == 2 && act_valid && stall < 3);
        if (!act_ready) stall++;
      end else if (mode == 2) act_ready = 1'($urandom_range(0, 1));
      else act_ready = 1;
      start = mode == 3 && beats == 4;
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk); #1;
    end
    start = 0; act_ready = 1;
    chk({tag, " beats"}, 64'(beats), 64'd8);
    chk({tag, " done count"}, 64'(ndone), 64'd1);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " act_valid"}, 64'(act_valid), 64'd0);
    chk({tag, " addr_err"}, 64'(addr_err), 64'd0);
    chk({tag, " cycle_index"}, 64'(cycle_index), 64'd0);
    chk({tag, " act_cycle"}, 64'(act_cycle), 64'd0);
    chk({tag, " act_package"}, act_package, 64'd0);
  endtask

  initial begin
    logic [7:0] old;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 3'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd2};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 3'd3};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd4};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 3'd5};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 3'd6};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 3'd7};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7};
    new_rows();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    #2 reset = 0;
    for (int a = 0; a < 32; a++) wr(a, 8'(a + 'h40));

    beats = 0; mon_en = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 start = tbl[i].start; act_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d valid", i), 64'(act_valid), 64'(tbl[i].valid));
      chk($sformatf("tbl%0d done", i), 64'(done), 64'(tbl[i].done));
      chk($sformatf("tbl%0d cidx", i), 64'(cycle_index), 64'(tbl[i].cidx));
      chk($sformatf("tbl%0d acyc", i), 64'(act_cycle), 64'(tbl[i].acyc));
    end
    start = 0;
    chk("tbl beats", 64'(beats), 64'd8);

    new_rows(); run(1, "backpressure");
    new_rows(); run(3, "start_busy");

    new_rows(); rowtab[0][3] = 2'd2; mon_en = 0; old = act[19];
    @(posedge clk); #1 start = 1; act_ready = 1;
    @(posedge clk); #1 start = 0; wr_en = 1; wr_addr = 5'd19; wr_data = 8'hA5;
    @(posedge clk); #1 wr_en = 0; act[19] = 8'hA5;
    @(negedge clk);
    chk("collision valid", 64'(act_valid), 64'd1);
    chk("collision old data", 64'(act_package[31:24]), 64'(old));
    for (int i = 0; i < 30 && busy; i++) @(posedge clk);
    #1 chk("collision finish", 64'(busy), 64'd0);
    run(0, "collision rerun");

    new_rows(); bad5 = 1; run(0, "badaddr");
    chk("addr_err set", 64'(addr_err), 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("addr_err sticky", 64'(addr_err), 64'd1);
    bad5 = 0; run(0, "after bad");
    chk("addr_err cleared", 64'(addr_err), 64'd0);

    repeat (4) begin
      new_rows();
      repeat (6) wr($urandom_range(0, 31), 8'($urandom));
      run(2, "random");
    end

    new_rows(); beats = 0; mon_en = 1;
    @(posedge clk); #1 start = 1; act_ready = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 40 && beats < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("reach beat3", 64'(beats), 64'd3);
    #2 reset = 1;
    #1 chk_reset_vals("midrun reset");
    repeat (2) begin
      @(negedge clk);
      chk("reset no done", 64'(done), 64'd0);
    end
    #2 reset = 0;
    run(0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
